ov_7670_capture_v2: RTL and testbench
=====================================

Name: ov_7670_capture_v2

Overview:
Parametrised second-generation camera pixel capture engine for the OV7670 path. It converts the sensor's byte stream (vsync/href/data) into framebuffer write transactions with address and pixel data. Over the first-generation capture it adds:
- selectable pixel mode (two-byte RGB565 pack or single-byte raw/gray)
- optional 2x2 decimation
- frame-aligned enable
- line-length checking
- address-overflow protection
- frame counting

Runs entirely in the camera pixel clock domain and feeds the frame buffer write port.

Parameters:
DATA_W, 8, sensor data bus width in bits
PIX_W, 16, output pixel width; must be >= 2*DATA_W
H_ACTIVE, 640, expected pixels per line (after byte pairing, before decimation)
V_ACTIVE, 480, expected lines per frame
ADDR_W, 19, framebuffer address width
MAX_PIX, 307200, framebuffer depth in pixels; must be <= 2**ADDR_W
FCNT_W, 8, frame counter width

Ports:
iclk  in  1  camera pixel clock (pclk); all logic on rising edge
ireset  in  1  asynchronous, active-low reset
ienable  in  1  capture enable; takes effect at frame boundaries as described below
imode  in  1  0 = RGB565 two-byte pack, 1 = single-byte mode
idecim  in  1  1 = keep only even columns of even lines
ivsync  in  1  sensor vsync, high = vertical blank
ihref  in  1  sensor href, high = valid byte on idata
idata  in  DATA_W  sensor data byte
owr_en  out  1  framebuffer write strobe, one cycle per pixel
oaddr  out  ADDR_W  write address, valid with owr_en
odata_out  out  PIX_W  pixel data, valid with owr_en
oframe_done  out  1  one-cycle pulse at end of a captured frame
oframe_cnt  out  FCNT_W  captured-frame count, wraps modulo 2**FCNT_W
oline_err  out  1  sticky: some line in current/last frame had length != H_ACTIVE
ooverflow  out  1  sticky: a write was suppressed because oaddr reached MAX_PIX
obusy  out  1  high while in ACTIVE state

Behaviour:
Reset (ireset low, asynchronous):
- All outputs 0, state IDLE, all counters 0.

Input sampling:
- ivsync, ihref, idata are registered once.
- Edge detection uses the registered copy and its previous value.
- All latencies below are counted from the registered sample.

State machine:
- IDLE: if ienable=1 -> WAIT_VS.
- WAIT_VS: wait for a vsync falling edge. At that edge:
  - imode and idecim are latched into shadow registers.
  - Address, column, row and byte-phase counters are cleared; oline_err and ooverflow are cleared.
  - Go to ACTIVE.
  - ienable=0 while in WAIT_VS -> IDLE.
- ACTIVE: capture (rules below). On a vsync rising edge:
  - oframe_done pulses for 1 cycle; oframe_cnt += 1.
  - If ienable=1 -> WAIT_VS, else -> IDLE.
  - Capture is never aborted mid-frame by ienable; the frame always completes.

Byte pairing and pixel output:
- Byte phase is cleared whenever registered href=0.
- Mode 0: phase 0 byte -> odata_out[2*DATA_W-1:DATA_W]; phase 1 byte -> low byte, which completes the pixel.
- Mode 1: every byte completes a pixel, zero-extended into odata_out.
- Unused upper bits of odata_out are 0.
- owr_en asserts exactly 1 cycle after the completing byte is registered; odata_out and oaddr are valid in the same cycle.
- odata_out holds its last value when owr_en=0.
- A half pixel (mode 0, phase 1 pending) at an href falling edge is discarded. This does not, on its own, set oline_err.

Counters:
- Column count increments per completed pixel and clears at href rising.
- Row count increments at each href falling edge.

Decimation:
- With idecim=1, a pixel is written only if column[0]=0 and row[0]=0.
- Column and row still count every pixel and line.

Address and overflow:
- oaddr starts at 0 each frame and increments by 1 after each issued write.
- If oaddr = MAX_PIX when a write is due: the write is suppressed, oaddr holds, and ooverflow is set. ooverflow is sticky until the next frame start.

Line-length check:
- At each href falling edge in ACTIVE, if column count != H_ACTIVE, oline_err is set. It is sticky until the next frame start.

Boundary and simultaneous events:
- vsync rising during href high: the frame ends; the in-flight completed pixel is still written on the next cycle; partial bytes are dropped.
- Frame start and end on the same registered sample cannot occur, since one edge direction is seen per cycle.
- ireset low mid-frame: immediate return to IDLE; no write issued.

Test Plan:
- Mode 0, idecim=0, 4x2 frame with bytes 0x12,0x34,... -> 8 writes, oaddr 0..7, first odata_out=0x1234, each 1 cycle after the 2nd byte; oframe_done pulses once; oframe_cnt=1.
- Mode 1, idecim=1, 4x4 frame, bytes 0x00..0x0F -> writes 0x0000,0x0002,0x0008,0x000A at oaddr 0..3 only.
- Line of H_ACTIVE-1 pixels plus a trailing odd byte in mode 0 -> oline_err=1 after href falls, half pixel not written; oline_err=0 after the next frame's vsync falling edge.
- MAX_PIX=4, frame of 6 pixels -> writes at oaddr 0..3, ooverflow=1, no further owr_en; oaddr stays 4.
- ienable rises mid-frame -> no writes until after the next vsync falling edge; ienable dropped mid-ACTIVE -> frame completes, then IDLE, obusy=0.
- ireset asserted during href with a pending pixel -> all outputs 0 within the same cycle, no owr_en after release until a new frame start.

Source files
------------

// File: rtl/ov_7670_capture_v2_if.sv
// ov_7670_capture_v2_if
//   Bundle of the sensor-side inputs and framebuffer-side outputs of the
//   OV7670 capture engine.
//   master : the capture engine (samples sensor/control, drives write port)
//   slave  : the environment (drives sensor/control, observes write port)
interface ov_7670_capture_v2_if #(
    parameter int DATA_W = 8,
    parameter int PIX_W  = 16,
    parameter int ADDR_W = 19,
    parameter int FCNT_W = 8
);
    logic              ienable;
    logic              imode;
    logic              idecim;
    logic              ivsync;
    logic              ihref;
    logic [DATA_W-1:0] idata;
    logic              owr_en;
    logic [ADDR_W-1:0] oaddr;
    logic [PIX_W-1:0]  odata_out;
    logic              oframe_done;
    logic [FCNT_W-1:0] oframe_cnt;
    logic              oline_err;
    logic              ooverflow;
    logic              obusy;

    modport master (
        input  ienable, imode, idecim, ivsync, ihref, idata,
        output owr_en, oaddr, odata_out, oframe_done, oframe_cnt,
               oline_err, ooverflow, obusy
    );

    modport slave (
        output ienable, imode, idecim, ivsync, ihref, idata,
        input  owr_en, oaddr, odata_out, oframe_done, oframe_cnt,
               oline_err, ooverflow, obusy
    );
endinterface

// File: rtl/ov_7670_capture_v2.sv
// ov_7670_capture_v2
//   OV7670 byte-stream to framebuffer-write converter, pclk domain only.
//   Ports:
//     iclk   : camera pixel clock, rising edge
//     ireset : asynchronous active-low reset
//     cam    : sensor inputs (ienable, imode, idecim, ivsync, ihref, idata)
//              and write port (owr_en, oaddr, odata_out) plus status
//              (oframe_done, oframe_cnt, oline_err, ooverflow, obusy)
//   Pixel modes: 0 = two bytes packed high-then-low, 1 = one byte per pixel.
//   Optional 2x2 decimation keeps even columns of even lines.
module ov_7670_capture_v2 #(
    parameter int DATA_W   = 8,
    parameter int PIX_W    = 16,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int MAX_PIX  = 307200,
    parameter int FCNT_W   = 8
) (
    input  logic                  iclk,
    input  logic                  ireset,
    ov_7670_capture_v2_if.master  cam
);
    // One spare bit so MAX_PIX == 2**ADDR_W is still representable.
    localparam int CNT_W = ADDR_W + 1;
    localparam int COL_W = $clog2(H_ACTIVE + 1) + 1;
    localparam int ROW_W = $clog2(V_ACTIVE + 1) + 1;
    localparam logic [CNT_W-1:0] MAX_A   = CNT_W'(MAX_PIX);
    localparam logic [COL_W-1:0] H_CHECK = COL_W'(H_ACTIVE);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic                vs_q, vs_p_q, href_q, href_p_q;
    logic [DATA_W-1:0]   data_q;
    logic                mode_q, mode_d, decim_q, decim_d;
    logic                phase_q, phase_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [COL_W-1:0]    col_q, col_d, col_base;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [CNT_W-1:0]    addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic                done_q, done_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                lerr_q, lerr_d, ovf_q, ovf_d;
    logic                complete, keep;

    wire vs_fall   =  vs_p_q   & ~vs_q;
    wire vs_rise   = ~vs_p_q   &  vs_q;
    wire href_rise = ~href_p_q &  href_q;
    wire href_fall =  href_p_q & ~href_q;

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q  <= IDLE;
            vs_q     <= 1'b0;
            vs_p_q   <= 1'b0;
            href_q   <= 1'b0;
            href_p_q <= 1'b0;
            data_q   <= '0;
            mode_q   <= 1'b0;
            decim_q  <= 1'b0;
            phase_q  <= 1'b0;
            hi_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            pix_q    <= '0;
            done_q   <= 1'b0;
            fcnt_q   <= '0;
            lerr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= cam.ivsync;
            vs_p_q   <= vs_q;
            href_q   <= cam.ihref;
            href_p_q <= href_q;
            data_q   <= cam.idata;
            mode_q   <= mode_d;
            decim_q  <= decim_d;
            phase_q  <= phase_d;
            hi_q     <= hi_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            pix_q    <= pix_d;
            done_q   <= done_d;
            fcnt_q   <= fcnt_d;
            lerr_q   <= lerr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        decim_d  = decim_q;
        phase_d  = phase_q;
        hi_d     = hi_q;
        col_d    = col_q;
        row_d    = row_q;
        // oaddr advances the cycle after each write is presented.
        addr_d   = addr_q + CNT_W'(wr_q);
        wr_d     = 1'b0;
        pix_d    = pix_q;
        done_d   = 1'b0;
        fcnt_d   = fcnt_q;
        lerr_d   = lerr_q;
        ovf_d    = ovf_q;
        complete = 1'b0;
        keep     = 1'b0;
        col_base = href_rise ? '0 : col_q;

        case (state_q)
            IDLE: begin
                if (cam.ienable) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (!cam.ienable) begin
                    state_d = IDLE;
                end else if (vs_fall) begin
                    state_d = ACTIVE;
                    mode_d  = cam.imode;
                    decim_d = cam.idecim;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    phase_d = 1'b0;
                    lerr_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // Frame end: a pixel already registered for write still
                    // goes out via wr_q; any byte seen now is dropped.
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                    phase_d = 1'b0;
                    state_d = cam.ienable ? WAIT_VS : IDLE;
                end else if (!href_q) begin
                    phase_d = 1'b0;   // discards any pending half pixel
                    if (href_fall) begin
                        if (row_q != '1) row_d = row_q + ROW_W'(1);
                        if (col_q != H_CHECK) lerr_d = 1'b1;
                    end
                end else begin
                    if (mode_q || phase_q) begin
                        complete = 1'b1;
                        phase_d  = 1'b0;
                    end else begin
                        hi_d    = data_q;
                        phase_d = 1'b1;
                    end
                    col_d = col_base;
                    if (complete) begin
                        // Saturate so an overlong line never wraps to H_ACTIVE.
                        if (col_base != '1) col_d = col_base + COL_W'(1);
                        keep = !decim_q || (!col_base[0] && !row_q[0]);
                        if (keep) begin
                            if (addr_d == MAX_A) begin
                                ovf_d = 1'b1;
                            end else begin
                                wr_d  = 1'b1;
                                pix_d = '0;
                                if (mode_q) pix_d[DATA_W-1:0]   = data_q;
                                else        pix_d[2*DATA_W-1:0] = {hi_q, data_q};
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cam.owr_en      = wr_q;
    assign cam.oaddr       = addr_q[ADDR_W-1:0];
    assign cam.odata_out   = pix_q;
    assign cam.oframe_done = done_q;
    assign cam.oframe_cnt  = fcnt_q;
    assign cam.oline_err   = lerr_q;
    assign cam.ooverflow   = ovf_q;
    assign cam.obusy       = (state_q == ACTIVE);
endmodule

// File: tb/tb_ov_7670_capture_v2.sv
// Bench for ov_7670_capture_v2: two instances share stimulus, one with a
// roomy framebuffer (A) and one with MAX_PIX=4 (B) to exercise overflow.
module tb_ov_7670_capture_v2;
    localparam int H = 4;
    localparam int MAXA = 64;
    localparam int MAXB = 4;

    logic iclk = 1'b0;
    logic ireset = 1'b0;
    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    ov_7670_capture_v2_if #(.DATA_W(8), .PIX_W(16), .ADDR_W(8), .FCNT_W(8)) ifa ();
    ov_7670_capture_v2_if #(.DATA_W(8), .PIX_W(16), .ADDR_W(8), .FCNT_W(8)) ifb ();

    assign ifb.ienable = ifa.ienable;
    assign ifb.imode   = ifa.imode;
    assign ifb.idecim  = ifa.idecim;
    assign ifb.ivsync  = ifa.ivsync;
    assign ifb.ihref   = ifa.ihref;
    assign ifb.idata   = ifa.idata;

    ov_7670_capture_v2 #(.DATA_W(8), .PIX_W(16), .H_ACTIVE(H), .V_ACTIVE(4),
        .ADDR_W(8), .MAX_PIX(MAXA), .FCNT_W(8)) dut_a (.iclk(iclk), .ireset(ireset), .cam(ifa));
    ov_7670_capture_v2 #(.DATA_W(8), .PIX_W(16), .H_ACTIVE(H), .V_ACTIVE(4),
        .ADDR_W(8), .MAX_PIX(MAXB), .FCNT_W(8)) dut_b (.iclk(iclk), .ireset(ireset), .cam(ifb));

    int total = 0;
    int bad = 0;

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t qa[$];
    wr_t qb[$];
    int wlog_a[$];
    int wlog_d[$];
    int done_cnt = 0;
    int lens[4];
    int exp_err, exp_ovf_b, exp_addr_a, exp_addr_b;
    int exp_fcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int bv(input int base, input int step, input int k);
        return (base + step * k) & 255;
    endfunction

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    // Expected writes of a frame straight from the pairing/decimation/depth
    // rules. Line l starts driving at c0+6, lines are separated by 3 idle
    // cycles, and a pixel appears 2 cycles after its completing byte is driven.
    task automatic model_frame(input int c0, input int mode, input int decim,
                               input int nl, input int base, input int step);
        int k, ls, aa, ab, np, bi, d;
        bit kp;
        k = 0; ls = c0 + 6; aa = 0; ab = 0;
        exp_err = 0; exp_ovf_b = 0;
        for (int l = 0; l < nl; l++) begin
            np = mode ? lens[l] : lens[l] / 2;
            if (np != H) exp_err = 1;
            for (int p = 0; p < np; p++) begin
                bi = mode ? p : 2 * p + 1;
                d  = mode ? bv(base, step, k + p)
                          : (bv(base, step, k + 2 * p) << 8) | bv(base, step, k + 2 * p + 1);
                kp = !decim || ((p % 2 == 0) && (l % 2 == 0));
                if (kp) begin
                    if (aa < MAXA) begin qa.push_back('{aa, d, ls + bi + 2}); aa++; end
                    if (ab < MAXB) begin qb.push_back('{ab, d, ls + bi + 2}); ab++; end
                    else exp_ovf_b = 1;
                end
            end
            k  += lens[l];
            ls += lens[l] + 3;
        end
        exp_addr_a = aa;
        exp_addr_b = ab;
    endtask

    task automatic run_frame(input int mode, input int decim, input int nl,
                             input int base, input int step, input int cap, input int en_mid);
        int c0, d0, k;
        ifa.imode  = mode[0];
        ifa.idecim = decim[0];
        ifa.ivsync = 1'b1;
        ifa.ihref  = 1'b0;
        c0 = cyc;
        if (cap != 0) model_frame(c0, mode, decim, nl, base, step);
        repeat (3) tick();
        ifa.ivsync = 1'b0;
        repeat (3) tick();
        if (cap != 0) begin
            chk("lerr_clear", {31'd0, ifa.oline_err}, 0);
            chk("ovf_clear", {31'd0, ifb.ooverflow}, 0);
            chk("busy_active", {31'd0, ifa.obusy}, 1);
        end
        d0 = done_cnt;
        k = 0;
        for (int l = 0; l < nl; l++) begin
            if (l == 0 && en_mid >= 0) ifa.ienable = en_mid[0];
            ifa.ihref = 1'b1;
            for (int j = 0; j < lens[l]; j++) begin
                ifa.idata = 8'(bv(base, step, k + j));
                tick();
            end
            k += lens[l];
            ifa.ihref = 1'b0;
            repeat (3) tick();
        end
        ifa.ivsync = 1'b1;
        repeat (4) tick();
        if (cap != 0) exp_fcnt++;
        chk("done_pulses", done_cnt - d0, cap);
        chk("fcnt_a", {24'd0, ifa.oframe_cnt}, exp_fcnt & 255);
        chk("fcnt_b", {24'd0, ifb.oframe_cnt}, exp_fcnt & 255);
        if (cap != 0) begin
            chk("pending_a", qa.size(), 0);
            chk("pending_b", qb.size(), 0);
            chk("lerr_a", {31'd0, ifa.oline_err}, exp_err);
            chk("ovf_a", {31'd0, ifa.ooverflow}, 0);
            chk("ovf_b", {31'd0, ifb.ooverflow}, exp_ovf_b);
            chk("addr_end_a", {24'd0, ifa.oaddr}, exp_addr_a);
            chk("addr_end_b", {24'd0, ifb.oaddr}, exp_addr_b);
        end
    endtask

    // Single compare process: every write must match the head of the
    // expected queue in address, data and cycle; overdue entries are misses.
    always @(negedge iclk) begin
        wr_t e;
        if (qa.size() > 0 && qa[0].cyc < cyc) begin
            e = qa.pop_front();
            chk("missing_wr_a", 32'(cyc), e.cyc);
        end
        if (qb.size() > 0 && qb[0].cyc < cyc) begin
            e = qb.pop_front();
            chk("missing_wr_b", 32'(cyc), e.cyc);
        end
        if (ifa.owr_en === 1'b1) begin
            wlog_a.push_back(int'(ifa.oaddr));
            wlog_d.push_back(int'(ifa.odata_out));
            if (qa.size() == 0) begin
                chk("unexpected_wr_a", {24'd0, ifa.oaddr}, 32'hFFFF_FFFF);
            end else begin
                e = qa.pop_front();
                chk("wr_addr_a", {24'd0, ifa.oaddr}, e.addr);
                chk("wr_data_a", {16'd0, ifa.odata_out}, e.data);
                chk("wr_cyc_a", 32'(cyc), e.cyc);
            end
        end
        if (ifb.owr_en === 1'b1) begin
            if (qb.size() == 0) begin
                chk("unexpected_wr_b", {24'd0, ifb.oaddr}, 32'hFFFF_FFFF);
            end else begin
                e = qb.pop_front();
                chk("wr_addr_b", {24'd0, ifb.oaddr}, e.addr);
                chk("wr_data_b", {16'd0, ifb.odata_out}, e.data);
                chk("wr_cyc_b", 32'(cyc), e.cyc);
            end
        end
        if (ifa.oframe_done === 1'b1) done_cnt++;
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_wr"},   {31'd0, ifa.owr_en}, 0);
        chk({nm, "_addr"}, {24'd0, ifa.oaddr}, 0);
        chk({nm, "_data"}, {16'd0, ifa.odata_out}, 0);
        chk({nm, "_done"}, {31'd0, ifa.oframe_done}, 0);
        chk({nm, "_fcnt"}, {24'd0, ifa.oframe_cnt}, 0);
        chk({nm, "_lerr"}, {31'd0, ifa.oline_err}, 0);
        chk({nm, "_ovf"},  {31'd0, ifb.ooverflow}, 0);
        chk({nm, "_busy"}, {31'd0, ifa.obusy}, 0);
    endtask

    initial begin
        ifa.ienable = 1'b0; ifa.imode = 1'b0; ifa.idecim = 1'b0;
        ifa.ivsync = 1'b1; ifa.ihref = 1'b0; ifa.idata = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        ireset = 1'b1;
        ifa.ienable = 1'b1;
        repeat (2) tick();

        // Mode 0, no decimation, 4x2: pins on first/last pixel.
        wlog_a.delete(); wlog_d.delete();
        lens = '{8, 8, 0, 0};
        run_frame(0, 0, 2, 8'h12, 8'h22, 1, -1);
        chk("t1_nwr", wlog_d.size(), 8);
        chk("t1_first", wlog_d[0], 32'h1234);
        chk("t1_last", wlog_d[7], 32'hEE10);
        chk("t1_fcnt", {24'd0, ifa.oframe_cnt}, 1);
        chk("t1_b_addr", {24'd0, ifb.oaddr}, 4);

        // Mode 1 with 2x2 decimation on a 4x4 frame of bytes 0..15.
        wlog_a.delete(); wlog_d.delete();
        lens = '{4, 4, 4, 4};
        run_frame(1, 1, 4, 0, 1, 1, -1);
        chk("t2_nwr", wlog_d.size(), 4);
        chk("t2_d0", wlog_d[0], 32'h0000);
        chk("t2_d1", wlog_d[1], 32'h0002);
        chk("t2_d2", wlog_d[2], 32'h0008);
        chk("t2_d3", wlog_d[3], 32'h000A);
        chk("t2_a3", wlog_a[3], 3);

        // Short line: 3 pixels plus an odd trailing byte.
        lens = '{7, 8, 0, 0};
        run_frame(0, 0, 2, 8'h40, 3, 1, -1);
        chk("t3_lerr", {31'd0, ifa.oline_err}, 1);

        // Good frame clears line error; ienable dropped mid-frame.
        lens = '{8, 8, 0, 0};
        run_frame(0, 0, 2, 8'h81, 5, 1, 0);
        chk("t4_idle_busy", {31'd0, ifa.obusy}, 0);

        // ienable rises mid-frame: nothing captured this frame.
        lens = '{4, 4, 0, 0};
        run_frame(1, 0, 2, 8'h20, 1, 0, 1);
        chk("t5_busy", {31'd0, ifa.obusy}, 0);

        // Next frame is captured: mode 1, full 4x4.
        lens = '{4, 4, 4, 4};
        run_frame(1, 0, 4, 8'hA0, 7, 1, -1);

        // Reset with a pixel registered but not yet written.
        ifa.imode = 1'b1; ifa.idecim = 1'b0;
        ifa.ivsync = 1'b1;
        repeat (3) tick();
        ifa.ivsync = 1'b0;
        repeat (3) tick();
        ifa.ihref = 1'b1;
        ifa.idata = 8'h55;
        tick();
        ireset = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_fcnt = 0;
        ifa.idata = 8'h66;
        repeat (2) tick();
        ireset = 1'b1;
        ifa.idata = 8'h77;
        repeat (2) tick();
        ifa.ihref = 1'b0;
        repeat (3) tick();
        ifa.ivsync = 1'b1;
        repeat (4) tick();
        chk("rst_fcnt", {24'd0, ifa.oframe_cnt}, 0);
        chk("rst_busy", {31'd0, ifa.obusy}, 0);

        // Capture resumes on the next frame start.
        lens = '{8, 8, 0, 0};
        run_frame(0, 0, 2, 8'h03, 9, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got cyc %0d want finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
